// File: rtl/sumsq_sqrt_rx.sv
// sumsq_sqrt_rx: buffers sum-of-squares samples in a FIFO and computes floor(sqrt(f)) and remainder, one root bit per cycle (clk, reset, f/valid_in in; root/rem/valid_out/busy/overflow out)
module sumsq_sqrt_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] f,
  input  logic        valid_in,
  output logic [9:0]  root,
  output logic [10:0] rem,
  output logic        valid_out,
  output logic        busy,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state;
  logic [19:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic pop, push, full, done, ge;
  logic [19:0] rad;
  logic [9:0] q;
  logic [12:0] r, rs, trial;
  logic [3:0] iter;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign pop = state == IDLE && cnt != '0;
  assign push = valid_in && (!full || pop);
  assign busy = state == CALC;
  always_comb begin
    rs = {r[10:0], rad[19:18]};
    trial = {1'b0, q, 2'b01};
    ge = rs >= trial;
  end
  always_ff @(posedge clk) if (push) mem[wp] <= f;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      rad <= '0;
      q <= '0;
      r <= '0;
      iter <= '0;
      done <= 1'b0;
      root <= '0;
      rem <= '0;
      valid_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= overflow | (valid_in & ~push);
      valid_out <= done;
      done <= 1'b0;
      if (done) begin
        root <= q;
        rem <= r[10:0];
      end
      if (state == IDLE) begin
        if (pop) begin
          rad <= mem[rp];
          q <= '0;
          r <= '0;
          iter <= 4'd9;
          state <= CALC;
        end
      end else begin
        rad <= rad << 2;
        q <= {q[8:0], ge};
        r <= ge ? rs - trial : rs;
        iter <= iter - 4'd1;
        if (iter == 4'd0) begin
          state <= IDLE;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sumsq_sqrt_rx.sv
// tb_sumsq_sqrt_rx: scoreboard bench for sumsq_sqrt_rx with directed vectors
module tb_sumsq_sqrt_rx;
  logic clk = 0, reset = 1, valid_in = 0;
  logic [19:0] f = '0;
  logic [9:0] root;
  logic [10:0] rem;
  logic valid_out, busy, overflow;
  typedef struct {int rt; int rm; int due;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0;
  sumsq_sqrt_rx #(.FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .f(f), .valid_in(valid_in),
    .root(root), .rem(rem), .valid_out(valid_out), .busy(busy), .overflow(overflow));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (sb.size() == 0) chk("unexpected_valid_out", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("root", int'(root), e.rt);
        chk("rem", int'(rem), e.rm);
        if (e.due >= 0) chk("latency_edge", cyc, e.due);
      end
    end
  end
  task automatic send(input int v, input int rt, input int rm, input bit acc, input bit track);
    exp_t e;
    valid_in = 1;
    f = 20'(v);
    if (acc) begin
      e.rt = rt; e.rm = rm; e.due = track ? cyc + 13 : -1;
      sb.push_back(e);
    end
    @(negedge clk);
    valid_in = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_root"}, int'(root), 0);
    chk({tag, "_rem"}, int'(rem), 0);
    chk({tag, "_valid_out"}, int'(valid_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask
  task automatic do_reset();
    reset = 1;
    valid_in = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  initial begin
    int nb;
    do_reset();
    chk_zero("reset_state");
    send(441, 21, 0, 1, 1);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("busy_cycles", nb, 10);
    drain();
    send(441, 21, 0, 1, 1);
    repeat (19) @(negedge clk);
    send(1737, 41, 56, 1, 1);
    repeat (19) @(negedge clk);
    send(5833, 76, 57, 1, 1);
    drain();
    repeat (5) @(negedge clk);
    chk("hold_root", int'(root), 76);
    chk("hold_rem", int'(rem), 57);
    send(0, 0, 0, 1, 1);
    drain();
    send(1048575, 1023, 2046, 1, 1);
    drain();
    for (int i = 0; i < 6; i++) send(100 + i, 10, i, i < 5, i == 0);
    chk("burst_overflow", int'(overflow), 1);
    drain();
    repeat (15) @(negedge clk);
    chk("burst_no_extra", sb.size(), 0);
    send(5833, 76, 57, 1, 1);
    repeat (6) @(negedge clk);
    chk("midcalc_busy_before", int'(busy), 1);
    reset = 1;
    #1;
    chk_zero("midcalc_reset");
    sb.delete();
    @(negedge clk);
    reset = 0;
    repeat (25) @(negedge clk);
    send(1737, 41, 56, 1, 1);
    drain();
    do_reset();
    for (int i = 0; i < 5; i++) send(100 + i, 10, i, 1, i == 0);
    repeat (7) @(negedge clk);
    chk("collision_busy_low", int'(busy), 0);
    send(106, 10, 6, 1, 0);
    chk("collision_overflow", int'(overflow), 0);
    drain();
    chk("collision_overflow_end", int'(overflow), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/sumsq_sqrt_rx.md
SUMSQ_SQRT_RX -- requirements
Module: sumsq_sqrt_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of accumulated-sum entries buffered (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port f, input, 20 bits: unsigned sum of squares from the MAC stage.
REQ-005 SHALL have port valid_in, input, 1 bit: f is valid this cycle (driven by the MAC valid_out); there is no backpressure.
REQ-006 SHALL have port root, output, 10 bits: floor(sqrt(f)) of the completed sample.
REQ-007 SHALL have port rem, output, 11 bits: f - root*root of the completed sample.
REQ-008 SHALL have port valid_out, output, 1 bit: one-cycle pulse marking root/rem as new.
REQ-009 SHALL have port busy, output, 1 bit: high while the FSM is in CALC.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when a valid sample is dropped.

Function
REQ-011 SHALL sample f into the FIFO at every rising edge where valid_in=1 and the FIFO is not full, or is full with a pop on the same edge.
REQ-012 SHALL drop the sample and set overflow=1 when valid_in=1, the FIFO is full and no pop occurs on that edge; overflow clears only on reset.
REQ-013 SHALL accept a simultaneous push and pop at any fill level with no change in occupancy and no data loss.
REQ-014 SHALL implement FSM states IDLE and CALC; the reset state is IDLE.
REQ-015 SHALL, in IDLE with the FIFO non-empty: pop the head, load the radicand, clear the partial root and remainder, set iter=9, and go to CALC; otherwise it stays in IDLE.
REQ-016 SHALL, in CALC, resolve one root bit per cycle, MSB first, by restoring digit-by-digit square root.
REQ-017 SHALL keep the working remainder at least 12 bits wide and signed, or use compare-before-subtract, so that no intermediate truncation occurs.
REQ-018 SHALL, on the edge completing iteration 0: register root and rem, drive valid_out=1 for exactly the following cycle, and return to IDLE.
REQ-019 SHALL have a latency of 12 edges from the sampling edge into an empty FIFO with FSM idle (edge k) to valid_out=1 (after edge k+12), i.e. 1 pop edge plus 10 CALC edges plus 1 write edge.
REQ-020 SHALL sustain a throughput of one result per 11 cycles under a continuous backlog.
REQ-021 SHALL hold root and rem at their last completed values while valid_out=0.
REQ-022 SHALL produce exact results for f=0 (root=0, rem=0) and f=1048575 (root=1023, rem=2046).
REQ-023 SHALL implement FIFO pointers that wrap modulo FIFO_DEPTH, with full/empty derived from an occupancy count or an extra pointer bit.
REQ-024 SHALL preserve arrival order: results appear in the same order samples were accepted.

Reset
REQ-025 SHALL, on reset assertion at any time including mid-CALC, immediately drive root=0, rem=0, valid_out=0, busy=0, overflow=0, empty the FIFO, and force the FSM to IDLE.
REQ-026 SHALL discard any in-flight computation on reset; no valid_out pulse is produced for it after release.
REQ-027 SHALL ignore valid_in while reset is high; the first sample is accepted on the first rising edge after release.

Verification
REQ-028 Single sample: f=441 pulsed for 1 cycle -> valid_out 12 edges later, root=21, rem=0, busy high for 10 cycles.
REQ-029 MAC sequence: f=441, 1737, 5833 spaced 20 cycles apart -> (21,0), (41,56), (76,57) in order.
REQ-030 Bounds: f=0 then f=1048575 -> (0,0) then (1023,2046); f=1048576 is not representable, so no check is applied.
REQ-031 Burst: six back-to-back valid samples 100..105 with FSM idle -> first five accepted (first popped on edge 2), sixth dropped, overflow=1, exactly five valid_out pulses for 100..104 (roots 10,10,10,10,10; rems 0,1,2,3,4).
REQ-032 Reset mid-CALC: f=5833, reset asserted 5 cycles into CALC -> outputs zero immediately, no valid_out afterward; a new f=1737 after release -> (41,56) with nominal latency.
REQ-033 Push/pop collision: FIFO full, valid_in coincides with an IDLE pop edge -> sample accepted, overflow stays 0, occupancy unchanged.
